// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// In-order issue controller sitting between the decoder and the ALU, multiplier
// and memory units. The decoded instruction is held (valid/ready handshake)
// until it is free of RAW/WAW hazards, its writeback cycle on the single
// register-file write port is unclaimed, and (for memory ops) the memory unit
// can accept it. Issued ops book their writeback cycle in a reservation
// shifter whose head drives the writeback stream that retires pending bits.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   dec_valid / dec_ready      decoder handshake (ready is combinational)
//   dec_r1, dec_r2, dec_uses_r2  source registers, r2 qualifier
//   dec_dest, dec_we           destination register and write enable
//   dec_is_alu/mul/mem         one-hot functional-unit class
//   mem_busy                   memory unit cannot accept an op this cycle
//   issue_alu/mul/mem          one-cycle issue pulses
//   wb_valid, wb_dest          register-file write this cycle (from shifter head)
//   idle                       nothing pending and no reservations outstanding
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int ALU_LATENCY      = 1,
    parameter int MEM_LATENCY      = 2,
    parameter int MUL_LATENCY      = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dec_valid,
    output logic                        dec_ready,
    input  logic [REG_ADDRESS_SIZE-1:0] dec_r1,
    input  logic [REG_ADDRESS_SIZE-1:0] dec_r2,
    input  logic                        dec_uses_r2,
    input  logic [REG_ADDRESS_SIZE-1:0] dec_dest,
    input  logic                        dec_we,
    input  logic                        dec_is_alu,
    input  logic                        dec_is_mul,
    input  logic                        dec_is_mem,
    input  logic                        mem_busy,
    output logic                        issue_alu,
    output logic                        issue_mul,
    output logic                        issue_mem,
    output logic                        wb_valid,
    output logic [REG_ADDRESS_SIZE-1:0] wb_dest,
    output logic                        idle
);

    localparam int NUM_REGS = 2 ** REG_ADDRESS_SIZE;

    // Scoreboard state
    logic [NUM_REGS-1:0]         pending_r;
    logic [MUL_LATENCY:1]        s_valid_r;
    logic [REG_ADDRESS_SIZE-1:0] s_dest_r [1:MUL_LATENCY];

    // Combinational helpers
    int                          lat_s;
    logic [NUM_REGS-1:0]         eff_pending_s;
    logic [NUM_REGS-1:0]         set_vec_s;
    logic [NUM_REGS-1:0]         clr_vec_s;
    logic                        slot_free_s;
    logic                        hazard_s;
    logic                        writes_dest_s;
    logic                        fire_s;

    // Writeback latency for the presented instruction class.
    function automatic int class_latency(input logic is_alu,
                                         input logic is_mul,
                                         input logic is_mem);
        int lat;
        case ({is_alu, is_mul, is_mem})
            3'b100:  lat = ALU_LATENCY;
            3'b010:  lat = MUL_LATENCY;
            3'b001:  lat = MEM_LATENCY;
            default: lat = ALU_LATENCY;
        endcase
        return lat;
    endfunction

    // Latency selection and pending view with same-cycle writeback bypass.
    always_comb begin
        lat_s         = class_latency(dec_is_alu, dec_is_mul, dec_is_mem);
        eff_pending_s = pending_r;
        if (s_valid_r[1]) begin
            eff_pending_s[s_dest_r[1]] = 1'b0;
        end else begin
            eff_pending_s = pending_r;
        end
        // x0 is hardwired and never hazards.
        eff_pending_s[0] = 1'b0;
    end

    // Writeback slot check: the op lands in S[L], so S[L+1] (which shifts into
    // S[L] at the coming edge) must be empty. Max latency always has a slot.
    always_comb begin
        slot_free_s = 1'b1;
        for (int k = 1; k <= MUL_LATENCY; k++) begin
            if (k == lat_s + 1) begin
                slot_free_s = ~s_valid_r[k];
            end else begin
                slot_free_s = slot_free_s;
            end
        end
    end

    // Issue condition and issue pulses.
    always_comb begin
        writes_dest_s = dec_we && (dec_dest != {REG_ADDRESS_SIZE{1'b0}});
        hazard_s      = eff_pending_s[dec_r1]
                     || (dec_uses_r2 && eff_pending_s[dec_r2])
                     || (writes_dest_s && eff_pending_s[dec_dest]);
        dec_ready     = ~reset && ~hazard_s && slot_free_s
                     && ~(dec_is_mem && mem_busy);
        fire_s        = dec_valid && dec_ready;
        issue_alu     = fire_s && dec_is_alu;
        issue_mul     = fire_s && dec_is_mul;
        issue_mem     = fire_s && dec_is_mem;
    end

    // Pending-bit set/clear vectors for the coming edge.
    always_comb begin
        set_vec_s = {NUM_REGS{1'b0}};
        clr_vec_s = {NUM_REGS{1'b0}};
        if (fire_s && writes_dest_s) begin
            set_vec_s[dec_dest] = 1'b1;
        end else begin
            set_vec_s = {NUM_REGS{1'b0}};
        end
        if (s_valid_r[1]) begin
            clr_vec_s[s_dest_r[1]] = 1'b1;
        end else begin
            clr_vec_s = {NUM_REGS{1'b0}};
        end
    end

    // Pending bits and reservation shifter; a new reservation overrides the
    // shift into its slot, and a set beats a clear on the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NUM_REGS{1'b0}};
            s_valid_r <= {MUL_LATENCY{1'b0}};
            for (int k = 1; k <= MUL_LATENCY; k++) begin
                s_dest_r[k] <= {REG_ADDRESS_SIZE{1'b0}};
            end
        end else begin
            pending_r <= (pending_r & ~clr_vec_s) | set_vec_s;
            for (int k = 1; k < MUL_LATENCY; k++) begin
                s_valid_r[k] <= s_valid_r[k+1];
                s_dest_r[k]  <= s_dest_r[k+1];
            end
            s_valid_r[MUL_LATENCY] <= 1'b0;
            s_dest_r[MUL_LATENCY]  <= {REG_ADDRESS_SIZE{1'b0}};
            if (fire_s && writes_dest_s) begin
                for (int k = 1; k <= MUL_LATENCY; k++) begin
                    if (k == lat_s) begin
                        s_valid_r[k] <= 1'b1;
                        s_dest_r[k]  <= dec_dest;
                    end
                end
            end
        end
    end

    // Writeback stream straight from the shifter head; idle from state only.
    always_comb begin
        wb_valid = s_valid_r[1];
        wb_dest  = s_dest_r[1];
        idle     = (pending_r == {NUM_REGS{1'b0}})
                && (s_valid_r == {MUL_LATENCY{1'b0}});
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
// Directed scenarios followed by random traffic. The reference model keeps a
// list of scheduled writebacks (absolute cycle, destination register); hazards,
// slot availability, the writeback stream and idle are all derived from it.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

    localparam int RA  = 5;
    localparam int LAT_ALU = 1;
    localparam int LAT_MEM = 2;
    localparam int LAT_MUL = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid;
    logic          dec_ready;
    logic [RA-1:0] dec_r1, dec_r2, dec_dest;
    logic          dec_uses_r2, dec_we;
    logic          dec_is_alu, dec_is_mul, dec_is_mem;
    logic          mem_busy;
    logic          issue_alu, issue_mul, issue_mem;
    logic          wb_valid;
    logic [RA-1:0] wb_dest;
    logic          idle;

    issue_scoreboard #(
        .REG_ADDRESS_SIZE(RA), .ALU_LATENCY(LAT_ALU),
        .MEM_LATENCY(LAT_MEM), .MUL_LATENCY(LAT_MUL)
    ) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_r1(dec_r1), .dec_r2(dec_r2), .dec_uses_r2(dec_uses_r2),
        .dec_dest(dec_dest), .dec_we(dec_we), .dec_is_alu(dec_is_alu),
        .dec_is_mul(dec_is_mul), .dec_is_mem(dec_is_mem), .mem_busy(mem_busy),
        .issue_alu(issue_alu), .issue_mul(issue_mul), .issue_mem(issue_mem),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [RA-1:0] dest;
    } wb_t;

    wb_t sched[$];
    int  t;
    int  tests = 0;
    int  fails = 0;
    bit  last_fire;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // A register is busy if a writeback to it is scheduled strictly later.
    function automatic bit model_pending(input logic [RA-1:0] r);
        if (r == '0) return 1'b0;
        foreach (sched[i]) if (sched[i].dest == r && sched[i].cyc > t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_slot_taken(input int cyc);
        foreach (sched[i]) if (sched[i].cyc == cyc) return 1'b1;
        return 1'b0;
    endfunction

    // Check one cycle at mid-period, update the model, advance past the edge.
    task automatic run_cycle();
        bit          e_wbv, e_ready, e_idle, reset_now;
        logic [RA-1:0] e_wbd;
        int          lat;
        #4;
        e_wbv = 1'b0;
        e_wbd = '0;
        e_idle = 1'b1;
        foreach (sched[i]) begin
            if (sched[i].cyc == t) begin
                e_wbv = 1'b1;
                e_wbd = sched[i].dest;
            end
            if (sched[i].cyc >= t) e_idle = 1'b0;
        end
        lat = dec_is_mul ? LAT_MUL : (dec_is_mem ? LAT_MEM : LAT_ALU);
        e_ready = !reset
               && !model_pending(dec_r1)
               && !(dec_uses_r2 && model_pending(dec_r2))
               && !(dec_we && dec_dest != '0 && model_pending(dec_dest))
               && (lat == LAT_MUL || !model_slot_taken(t + lat))
               && !(dec_is_mem && mem_busy);
        check("dec_ready", {31'd0, dec_ready}, {31'd0, e_ready});
        check("issue_alu", {31'd0, issue_alu}, {31'd0, dec_valid && e_ready && dec_is_alu});
        check("issue_mul", {31'd0, issue_mul}, {31'd0, dec_valid && e_ready && dec_is_mul});
        check("issue_mem", {31'd0, issue_mem}, {31'd0, dec_valid && e_ready && dec_is_mem});
        check("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
        if (e_wbv) check("wb_dest", {27'd0, wb_dest}, {27'd0, e_wbd});
        check("idle", {31'd0, idle}, {31'd0, e_idle});
        last_fire = dec_valid && dec_ready;
        if (dec_valid && e_ready && dec_we && dec_dest != '0) begin
            wb_t e;
            e.cyc  = t + lat;
            e.dest = dec_dest;
            sched.push_back(e);
        end
        reset_now = reset;
        @(posedge clk);
        #1;
        t++;
        if (reset_now) sched.delete();
        for (int i = sched.size() - 1; i >= 0; i--) if (sched[i].cyc < t) sched.delete(i);
    endtask

    // cls: 0 = ALU, 1 = MUL, 2 = MEM
    task automatic set_op(input bit v, input int cls, input logic [RA-1:0] r1,
                          input logic [RA-1:0] r2, input bit u2,
                          input logic [RA-1:0] d, input bit we, input bit busy);
        dec_valid   = v;
        dec_is_alu  = (cls == 0);
        dec_is_mul  = (cls == 1);
        dec_is_mem  = (cls == 2);
        dec_r1      = r1;
        dec_r2      = r2;
        dec_uses_r2 = u2;
        dec_dest    = d;
        dec_we      = we;
        mem_busy    = busy;
    endtask

    // Present the current op until it issues; returns the number of stalls.
    task automatic hold(output int stalls);
        stalls = 0;
        for (int n = 0; n < 12; n++) begin
            run_cycle();
            if (last_fire) return;
            stalls++;
        end
    endtask

    task automatic drain(input int n);
        set_op(1'b0, 0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    int s;

    initial begin
        t = 0;
        reset = 1'b1;
        set_op(1'b1, 0, 5'd2, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Reset held with a valid op presented
        run_cycle();
        run_cycle();
        check("rst_idle", {31'd0, idle}, 32'd1);
        reset = 1'b0;

        // ALU x1 <- x2 issues immediately, writes back next cycle
        hold(s);
        check("alu_first_stalls", s, 32'd0);
        drain(3);

        // RAW stall behind a multiply, released by the bypass
        set_op(1'b1, 1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
        hold(s);
        check("raw_mul_stalls", s, 32'd0);
        set_op(1'b1, 0, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        hold(s);
        check("raw_stalls", s, 32'd4);
        drain(8);

        // Writeback-port conflict
        set_op(1'b1, 1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
        hold(s);
        drain(3);
        set_op(1'b1, 0, 5'd6, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        hold(s);
        check("conflict_stalls", s, 32'd1);
        drain(8);

        // x0 destination and x0 reads
        set_op(1'b1, 1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
        hold(s);
        check("x0_mul_stalls", s, 32'd0);
        set_op(1'b1, 0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        hold(s);
        check("x0_alu_stalls", s, 32'd0);
        drain(6);
        check("x0_idle", {31'd0, idle}, 32'd1);

        // Memory unit busy for three cycles
        set_op(1'b1, 2, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            check("mem_busy_hold", {31'd0, last_fire}, 32'd0);
        end
        mem_busy = 1'b0;
        run_cycle();
        check("mem_issue", {31'd0, last_fire}, 32'd1);
        drain(4);

        // Reset while a multiply is in flight
        set_op(1'b1, 1, 5'd1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
        hold(s);
        drain(1);
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            check("midrst_wb", {31'd0, wb_valid}, 32'd0);
            check("midrst_idle", {31'd0, idle}, 32'd1);
        end

        // Random traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            set_op(($urandom_range(9) < 7), int'($urandom_range(2)),
                   5'($urandom_range(7)), 5'($urandom_range(7)),
                   1'($urandom_range(1)), 5'($urandom_range(7)),
                   ($urandom_range(7) != 0), ($urandom_range(3) == 0));
            reset = ($urandom_range(49) == 0);
            run_cycle();
        end
        reset = 1'b0;
        drain(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order issue controller between the instruction decoder and the ALU, multiplier and memory functional units.
- Holds the decoded instruction (valid/ready) until three conditions are met: no RAW or WAW hazard on the register file, a free writeback slot on the single register-file write port, and a memory unit that can accept (memory ops only).
- Emits one-hot issue pulses and a scheduled writeback stream (wb_valid/wb_dest) that retires scoreboard entries.

Parameters:
- REG_ADDRESS_SIZE, 5: register index width; register count is 2**REG_ADDRESS_SIZE.
- ALU_LATENCY, 1: cycles from issue to writeback for ALU and branch ops.
- MEM_LATENCY, 2: cycles from issue to writeback for memory ops.
- MUL_LATENCY, 5: cycles from issue to writeback for multiply ops. Must be >= the other two latencies; sets the reservation-shifter depth.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decoder presents an instruction.
- dec_ready  out  1  instruction issues this cycle when dec_valid is also high.
- dec_r1  in  REG_ADDRESS_SIZE  source register 1.
- dec_r2  in  REG_ADDRESS_SIZE  source register 2.
- dec_uses_r2  in  1  r2 is read (low for immediate forms).
- dec_dest  in  REG_ADDRESS_SIZE  destination register.
- dec_we  in  1  instruction writes dec_dest.
- dec_is_alu  in  1  ALU class (includes branch/jump).
- dec_is_mul  in  1  multiply class.
- dec_is_mem  in  1  memory class.
- mem_busy  in  1  memory unit cannot accept an op this cycle.
- issue_alu  out  1  one-cycle issue pulse to the ALU.
- issue_mul  out  1  one-cycle issue pulse to the multiplier.
- issue_mem  out  1  one-cycle issue pulse to the memory unit.
- wb_valid  out  1  register-file write occurs this cycle.
- wb_dest  out  REG_ADDRESS_SIZE  register written this cycle.
- idle  out  1  no pending writes and no reservations.

Behaviour:
- Reset value of every output is 0, except idle = 1.
- While reset is high, dec_ready = 0 and no issue pulse fires.
- State:
  - pending bit vector, one bit per register.
  - reservation shifter S[1..MUL_LATENCY], each entry {valid, dest}.
- Latency L: selected by class (is_alu/is_mul/is_mem). Class inputs are one-hot when dec_valid is high; other combinations are never driven.
- Every cycle, S[k] <= S[k+1], and S[MUL_LATENCY] <= empty unless written by an issue.
- wb_valid and wb_dest are driven directly from S[1]. An op issued in cycle t with latency L writes back in cycle t+L.
- Register x0:
  - Reading x0 never hazards.
  - An op with dest 0 or dec_we = 0 makes no reservation and sets no pending bit; it never produces wb_valid.
- Effective pending(r) = pending[r] AND NOT (wb_valid AND wb_dest == r). A register written back this cycle is treated as ready (bypass).
- Issue condition, all combinational (dec_ready):
  - NOT effective pending(dec_r1).
  - NOT (dec_uses_r2 AND effective pending(dec_r2)).
  - NOT (dec_we AND dest != 0 AND effective pending(dec_dest)).
  - The writeback slot is free: S[L+1] is empty now. For L = MUL_LATENCY the slot is always free.
  - NOT (dec_is_mem AND mem_busy).
- On issue (dec_valid AND dec_ready):
  - Exactly one issue_* pulses in that same cycle.
  - If the op writes a nonzero dest: set pending[dest], and write S[L] <= {1, dest} at the edge, overriding the shift into S[L].
- pending[wb_dest] clears at the edge ending a wb_valid cycle. If the same register is set and cleared on the same edge, the set wins.
- idle = (pending == 0) AND all S entries empty.
- Outputs do not depend on dec_valid except issue_*. dec_ready may be high with dec_valid low.
- Reset mid-operation clears all pending bits and reservations at that edge. No writeback from in-flight ops is emitted afterwards.

Test Plan:
- Reset: hold reset 2 cycles with dec_valid = 1 → dec_ready = 0, issue_* = 0, wb_valid = 0, idle = 1. After release, an ALU op x1 ← x2 issues immediately; wb_valid = 1 with wb_dest = 1 one cycle later.
- RAW stall: mul x5 issued at t0, then ALU op reading x5 → dec_ready = 0 for t1..t4. At t5, wb_valid = 1 with wb_dest = 5, and the ALU op issues in t5 (bypass); its writeback lands at t6.
- Writeback conflict: mul x3 at t0, then ALU op x4 ← x6 presented at t4 → stalled at t4 (slot held by the mul), issues at t5; wb_dest = 3 at t5 and wb_dest = 4 at t6, never both in one cycle.
- x0: mul with dest x0 and dec_we = 1, followed by an ALU op reading x0 → both issue back-to-back; wb_valid never asserted; idle stays 1.
- mem_busy: load x7 with mem_busy = 1 for 3 cycles → dec_ready = 0 for those cycles. The cycle mem_busy drops, issue_mem pulses; wb_dest = 7 two cycles later.
- Reset mid-flight: mul x9 at t0, reset asserted at t2 → no wb_valid at t5, pending[9] = 0, idle = 1 from t3.
